tinycpu_loader: RTL and testbench

Byte-stream program loader that fills the 4096×16 instruction/data memory of the stack CPU and then starts it. It is the writing end of the memory the CPU fetches from: a host pushes a framed byte stream over a valid/ready handshake, and the loader assembles 16-bit words and issues sequential memory writes. After a complete frame, it pulses the CPU's `run` input.

---
 rtl/tinycpu_loader.sv | 158 +++++++++++++++
 tb/tb_tinycpu_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/tinycpu_loader.sv
// Framed byte-stream loader: assembles big-endian words into sequential memory writes, then pulses run.
// Optional LOADER_CSUM_EN adds a trailing 8-bit zero-sum checksum byte that gates the run pulse.
module tinycpu_loader #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_d,
  output logic          run,
  output logic          busy,
  output logic          err
);

  localparam int unsigned CW = 12;

  typedef enum logic [2:0] {
    S_ADDR_H = 3'd0,
    S_ADDR_L = 3'd1,
    S_CNT_H  = 3'd2,
    S_CNT_L  = 3'd3,
    S_DATA_H = 3'd4,
    S_DATA_L = 3'd5,
    S_CSUM   = 3'd6,
    S_FIN    = 3'd7
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  state_t        w_tail;
  logic [7:0]    r_hi;
  logic [AW-1:0] r_addr;
  logic [CW-1:0] r_cnt;
  logic          r_in_ready;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_d;
  logic          r_run;
  logic          r_busy;
  logic          w_accept;
  logic          w_we_nxt;
  logic          w_run_nxt;
  logic          w_err_nxt;
  logic [AW-1:0] w_addr_rx;
  logic [CW-1:0] w_cnt_rx;
  logic [DW-1:0] w_word;

  // r_hi always holds the previously accepted byte, i.e. the high half of the field now completing
  assign w_accept  = in_valid && r_in_ready;
  assign w_addr_rx = AW'({r_hi[3:0], in_data});
  assign w_cnt_rx  = CW'({r_hi[3:0], in_data});
  assign w_word    = DW'({r_hi, in_data});

`ifdef LOADER_CSUM_EN
  logic [7:0] r_sum;
  logic [7:0] w_sum_nxt;
  logic       r_err;

  assign w_tail = S_CSUM;

  // Running modulo-256 sum restarts at ADDR_H; verdict is formed as CSUM is accepted
  always_comb begin
    w_sum_nxt = r_sum;
    w_err_nxt = r_err;
    if (w_accept) begin
      w_sum_nxt = (r_state == S_ADDR_H) ? in_data : 8'(r_sum + in_data);
      if (r_state == S_ADDR_H) w_err_nxt = 1'b0;
      if (r_state == S_CSUM)   w_err_nxt = (8'(r_sum + in_data) != 8'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= 8'd0;
      r_err <= 1'b0;
    end else begin
      r_sum <= w_sum_nxt;
      r_err <= w_err_nxt;
    end
  end

  assign err = r_err;
`else
  assign w_tail    = S_FIN;
  assign w_err_nxt = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_ADDR_H;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_we_nxt    = 1'b0;
    w_run_nxt   = 1'b0;
    case (r_state)
      S_ADDR_H: if (w_accept) w_state_nxt = S_ADDR_L;
      S_ADDR_L: if (w_accept) w_state_nxt = S_CNT_H;
      S_CNT_H:  if (w_accept) w_state_nxt = S_CNT_L;
      S_CNT_L:  if (w_accept) w_state_nxt = (w_cnt_rx == '0) ? w_tail : S_DATA_H;
      S_DATA_H: if (w_accept) w_state_nxt = S_DATA_L;
      S_DATA_L: begin
        if (w_accept) begin
          w_we_nxt    = 1'b1;
          w_state_nxt = (r_cnt == CW'(1)) ? w_tail : S_DATA_H;
        end
      end
      S_CSUM:   if (w_accept) w_state_nxt = S_FIN;
      S_FIN:    w_state_nxt = S_ADDR_H;
      default:  w_state_nxt = S_ADDR_H;
    endcase
    w_run_nxt = (w_state_nxt == S_FIN) && !w_err_nxt;
  end

  // Registered outputs and frame datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi       <= 8'd0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_in_ready <= 1'b1;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_d    <= '0;
      r_run      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_in_ready <= (w_state_nxt != S_FIN);
      r_busy     <= (w_state_nxt != S_ADDR_H);
      r_mem_we   <= w_we_nxt;
      r_run      <= w_run_nxt;
      if (w_accept) r_hi <= in_data;
      if (w_accept && (r_state == S_ADDR_L)) r_addr <= w_addr_rx;
      if (w_accept && (r_state == S_CNT_L))  r_cnt  <= w_cnt_rx;
      if (w_we_nxt) begin
        r_mem_addr <= r_addr;
        r_mem_d    <= w_word;
        r_addr     <= r_addr + AW'(1);
        r_cnt      <= r_cnt - CW'(1);
      end
    end
  end

  assign in_ready = r_in_ready;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_d    = r_mem_d;
  assign run      = r_run;
  assign busy     = r_busy;

endmodule

// File: tb/tb_tinycpu_loader.sv
// Self-checking bench for tinycpu_loader: directed and randomized frames against a frame-level model.
module tb_tinycpu_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [15:0] mem_d;
  logic        run;
  logic        busy;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [27:0] wq[$];
  logic [15:0] wlist[$];
  int          run_cnt = 0;
  bit          gap_en  = 1'b0;

  tinycpu_loader #(.AW(12), .DW(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_d    (mem_d),
    .run      (run),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Observed write and run events
  always @(negedge clk) begin
    if (mem_we === 1'b1) wq.push_back({mem_addr, mem_d});
    if (run === 1'b1) run_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_mem_we"},   32'(mem_we),   32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_d"},    32'(mem_d),    32'd0);
    check({tag, "_run"},      32'(run),      32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_err"},      32'(err),      32'd0);
  endtask

  task automatic send(input logic [7:0] b);
    int guard;
    if (gap_en)
      for (int k = 0; k < 8 && $urandom_range(0, 1) == 1; k++) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Sends one frame built from wlist and checks writes, run and handshake timing against the model
  task automatic frame(input logic [7:0] ah, input logic [7:0] al, input logic [7:0] ch,
                       input logic [7:0] cl, input bit bad_cs, input string tag);
    logic [11:0] a0;
    int          n;
    logic [7:0]  sum;
    logic [7:0]  cs;
    int          runs0;
    bit          exp_run;
    bit          exp_we;
    a0    = {ah[3:0], al};
    n     = int'({ch[3:0], cl});
    wq.delete();
    runs0 = run_cnt;
    sum   = ah;
    send(ah);
    check({tag, "_busy_hdr"}, 32'(busy), 32'd1);
    check({tag, "_err_clr"},  32'(err),  32'd0);
    send(al); sum = 8'(sum + al);
    send(ch); sum = 8'(sum + ch);
    send(cl); sum = 8'(sum + cl);
    for (int i = 0; i < n; i++) begin
      send(wlist[i][15:8]); sum = 8'(sum + wlist[i][15:8]);
      send(wlist[i][7:0]);  sum = 8'(sum + wlist[i][7:0]);
    end
`ifdef LOADER_CSUM_EN
    cs = 8'(8'd0 - sum);
    if (bad_cs) cs = 8'(cs + 8'd1);
    send(cs);
    exp_run = !bad_cs;
    exp_we  = 1'b0;
`else
    cs = sum;
    if (bad_cs) $display("note: %s checksum byte %0h not sent in this build", tag, cs);
    exp_run = 1'b1;
    exp_we  = (n > 0);
`endif
    @(negedge clk);
    check({tag, "_fin_run"},   32'(run),      32'(exp_run));
    check({tag, "_fin_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_fin_busy"},  32'(busy),     32'd1);
    check({tag, "_fin_err"},   32'(err),      32'(!exp_run));
    check({tag, "_fin_we"},    32'(mem_we),   32'(exp_we));
    @(negedge clk);
    check({tag, "_post_run"},   32'(run),      32'd0);
    check({tag, "_post_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_post_busy"},  32'(busy),     32'd0);
    check({tag, "_post_err"},   32'(err),      32'(!exp_run));
    check({tag, "_nwrites"},    32'(wq.size()), 32'(n));
    for (int i = 0; i < n; i++)
      if (i < wq.size())
        check($sformatf("%s_wr%0d", tag, i), 32'(wq[i]), 32'({12'(a0 + 12'(i)), wlist[i]}));
    check({tag, "_runs"}, 32'(run_cnt - runs0), 32'(exp_run));
  endtask

  task automatic rand_words(input int n);
    wlist.delete();
    for (int i = 0; i < n; i++) wlist.push_back(16'($urandom));
  endtask

  initial begin
    int runs0;
    logic [11:0] ra;
    int rn;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst0");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("idle0");

    wlist.delete(); wlist.push_back(16'h1005); wlist.push_back(16'hE000);
    frame(8'h00, 8'h10, 8'h00, 8'h02, 1'b0, "basic");

    wlist.delete(); wlist.push_back(16'h1111); wlist.push_back(16'h2222);
    frame(8'h0F, 8'hFF, 8'h00, 8'h02, 1'b0, "wrap");

    rand_words(1);
    frame(8'hF0, 8'h23, 8'hF0, 8'h01, 1'b0, "nibble");

    wlist.delete();
    frame(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "n0");

`ifdef LOADER_CSUM_EN
    rand_words(2);
    frame(8'h01, 8'h00, 8'h00, 8'h02, 1'b1, "badcs");
    repeat (3) begin
      @(negedge clk);
      check("err_sticky", 32'(err), 32'd1);
    end
    rand_words(1);
    frame(8'h02, 8'h00, 8'h00, 8'h01, 1'b0, "after_bad");
`endif

    // Abort inside the first word's DATA_L: nothing from this frame may reach memory or run
    wq.delete();
    runs0 = run_cnt;
    send(8'h00); send(8'h40); send(8'h00); send(8'h02); send(8'h12);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("after_rst");
    check("abort_writes", 32'(wq.size()), 32'd0);
    check("abort_runs",   32'(run_cnt - runs0), 32'd0);

    wlist.delete(); wlist.push_back(16'h3456); wlist.push_back(16'h789A);
    frame(8'h00, 8'h40, 8'h00, 8'h02, 1'b0, "fresh");

    gap_en = 1'b1;
    ra = 12'($urandom);
    rand_words(16);
    frame({4'($urandom), ra[11:8]}, ra[7:0], 8'h00, 8'h10, 1'b0, "gap16");
    for (int f = 0; f < 3; f++) begin
      ra = 12'($urandom);
      rn = $urandom_range(0, 8);
      rand_words(rn);
      frame({4'h0, ra[11:8]}, ra[7:0], 8'h00, 8'(rn), 1'b0, $sformatf("rnd%0d", f));
    end
    gap_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
